// File: rtl/vram_pkg.sv
// Shared types and constants for the banked video-RAM controller.
// Holds the CPU-port FSM states, the transfer kinds and the bank-width helper.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // What the DONE cycle presents on cpu_do: a held value, fresh RAM data, or all-ones.
  typedef enum logic [1:0] {
    XFER_WRITE  = 2'd0,
    XFER_READ   = 2'd1,
    XFER_LOCKED = 2'd2
  } xfer_t;

  localparam logic [1:0] MODE_XFER = 2'd3;

  function automatic int calc_bank_w(input int num_banks);
    int w;
    w = 1;
    for (int i = 1; i < 4; i++) begin
      if ((1 << w) < num_banks) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vram_bank_ram.sv
// Single-port synchronous RAM for one VRAM bank, read-first, advancing only on ce.
// Contents are never reset.
module vram_bank_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_sys) begin
    if (ce) begin
      if (we) mem[addr] <= di;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/vram_bank_ctrl.sv
// Banked VRAM: NUM_BANKS single-port banks shared by the PPU fetch path (absolute
// priority) and a CPU req/ack port with VBK bank select and mode-3 lockout.
module vram_bank_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 2,
  parameter int LOCK_EN   = 1
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ce,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_di,
  output logic [DATA_W-1:0]           cpu_do,
  output logic                        cpu_ack,
  input  logic                        vbk_we,
  input  logic [7:0]                  vbk_di,
  output logic [7:0]                  vbk_do,
  input  logic                        lcd_on,
  input  logic [1:0]                  lcd_mode,
  input  logic                        vid_rd,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic [NUM_BANKS*DATA_W-1:0] vid_data
);

  localparam int BANK_W = calc_bank_w(NUM_BANKS);
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);

  state_t                      state, state_nxt;
  xfer_t                       xfer;
  logic [BANK_W-1:0]           bank, gnt_bank;
  logic                        locked, pending, grant, lock_done;
  logic                        vid_vld_p1;
  logic [DATA_W-1:0]           cpu_hold;
  logic [NUM_BANKS*DATA_W-1:0] vid_hold, ram_flat;
  logic [DATA_W-1:0]           ram_q [NUM_BANKS];
  logic [ADDR_W-1:0]           ram_addr;
  logic                        unused_vbk;

  assign unused_vbk = &{1'b0, vbk_di[7:BANK_W]};

  assign locked    = (LOCK_EN != 0) && lcd_on && (lcd_mode == MODE_XFER);
  assign pending   = cpu_req && (state != DONE);
  assign lock_done = pending && locked;
  assign grant     = pending && !locked && !vid_rd;
  assign ram_addr  = vid_rd ? vid_addr : cpu_addr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vram_bank_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ram (
      .clk_sys(clk_sys),
      .ce     (ce),
      .addr   (ram_addr),
      .we     (grant && cpu_we && (bank == BANK_W'(b))),
      .di     (cpu_di),
      .dout   (ram_q[b])
    );
    assign ram_flat[b*DATA_W +: DATA_W] = ram_q[b];
  end

  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (lock_done || grant) state_nxt = DONE;
        else if (pending)       state_nxt = WAIT;
        else                    state_nxt = IDLE;
      end
      DONE: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is taken straight from the bank during the ack cycle, then held.
  always_comb begin
    cpu_do = cpu_hold;
    if (state == DONE) begin
      if (xfer == XFER_READ)        cpu_do = ram_q[gnt_bank];
      else if (xfer == XFER_LOCKED) cpu_do = '1;
    end
  end

  assign vid_data = vid_vld_p1 ? ram_flat : vid_hold;
  assign vbk_do   = {{(8-BANK_W){1'b1}}, bank};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      xfer       <= XFER_WRITE;
      bank       <= '0;
      gnt_bank   <= '0;
      vid_vld_p1 <= 1'b0;
      cpu_hold   <= '1;
      vid_hold   <= '0;
    end else if (ce) begin
      state      <= state_nxt;
      vid_vld_p1 <= vid_rd;
      if (vbk_we) bank <= vbk_di[BANK_W-1:0] & BANK_MASK;
      if (grant) begin
        gnt_bank <= bank;
        xfer     <= cpu_we ? XFER_WRITE : XFER_READ;
      end else if (lock_done) begin
        xfer     <= cpu_we ? XFER_WRITE : XFER_LOCKED;
      end
      if (state == DONE) cpu_hold <= cpu_do;
      if (vid_vld_p1)    vid_hold <= vid_data;
    end
  end

endmodule

// File: tb/tb_vram_bank_ctrl.sv
// Bench for vram_bank_ctrl: directed vector table, hand sequences for contention,
// bank switch, lockout, ce freeze and reset, plus randomized traffic against a byte-array model.
module tb_vram_bank_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset, ce, cpu_req, cpu_we, vbk_we, lcd_on, vid_rd, cpu_ack;
  logic [12:0] cpu_addr, vid_addr;
  logic [7:0]  cpu_di, cpu_do, vbk_di, vbk_do;
  logic [1:0]  lcd_mode;
  logic [15:0] vid_data;

  vram_bank_ctrl #(.ADDR_W(13), .DATA_W(8), .NUM_BANKS(2), .LOCK_EN(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .vbk_we(vbk_we), .vbk_di(vbk_di), .vbk_do(vbk_do),
    .lcd_on(lcd_on), .lcd_mode(lcd_mode),
    .vid_rd(vid_rd), .vid_addr(vid_addr), .vid_data(vid_data)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        we;
    logic        bank;
    logic [12:0] addr;
    logic [7:0]  di;
    logic        lon;
    logic [1:0]  mode;
    logic [7:0]  exp_do;
    int          exp_lat;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] mdl [2][128];
  logic       cur_bank;
  logic [7:0] last_do;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_bank(input logic b);
    vbk_we = 1'b1;
    vbk_di = {7'h55, b};
    step();
    vbk_we = 1'b0;
    cur_bank = b;
    chk("vbk_do", vbk_do, {7'h7F, b});
  endtask

  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [7:0] di,
                        input int nvid, input logic [7:0] exp_do, input int exp_lat,
                        input string nm);
    int lat;
    logic lk;
    logic [6:0] va;
    lk = lcd_on && (lcd_mode == 2'd3);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_di = di;
    lat = 0;
    va = '0;
    while (1) begin
      if (lat < nvid) begin
        va = 7'($urandom_range(64, 127));
        vid_rd = 1'b1;
        vid_addr = {6'd0, va};
      end else begin
        vid_rd = 1'b0;
      end
      step();
      lat++;
      if (lat <= nvid) chk({nm, "_vid"}, vid_data, {mdl[1][va], mdl[0][va]});
      if (cpu_ack) break;
      if (lat > 20) begin
        chk({nm, "_timeout"}, 32'(lat), 32'(exp_lat));
        break;
      end
    end
    cpu_req = 1'b0;
    vid_rd = 1'b0;
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_do"}, cpu_do, exp_do);
    if (we && !lk) mdl[cur_bank][addr[6:0]] = di;
    if (!we) last_do = exp_do;
    step();
    chk({nm, "_ackpulse"}, cpu_ack, 1'b0);
  endtask

  initial begin
    int lat_e;
    logic we_r, lk_r;
    logic [6:0] a_r;
    logic [7:0] d_r, e_r;

    tbl[0]  = '{1'b1, 1'b0, 13'h0010, 8'hA5, 1'b0, 2'd0, 8'hFF, 1};
    tbl[1]  = '{1'b1, 1'b1, 13'h0010, 8'h5A, 1'b0, 2'd0, 8'hFF, 1};
    tbl[2]  = '{1'b0, 1'b1, 13'h0010, 8'h00, 1'b0, 2'd0, 8'h5A, 1};
    tbl[3]  = '{1'b0, 1'b0, 13'h0010, 8'h00, 1'b0, 2'd0, 8'hA5, 1};
    tbl[4]  = '{1'b1, 1'b0, 13'h0020, 8'h33, 1'b0, 2'd0, 8'hA5, 1};
    tbl[5]  = '{1'b1, 1'b0, 13'h0020, 8'h77, 1'b1, 2'd3, 8'hA5, 1};
    tbl[6]  = '{1'b0, 1'b0, 13'h0020, 8'h00, 1'b1, 2'd0, 8'h33, 1};
    tbl[7]  = '{1'b0, 1'b0, 13'h0020, 8'h00, 1'b1, 2'd3, 8'hFF, 1};
    tbl[8]  = '{1'b0, 1'b0, 13'h0020, 8'h00, 1'b0, 2'd3, 8'h33, 1};
    tbl[9]  = '{1'b0, 1'b1, 13'h0010, 8'h00, 1'b1, 2'd1, 8'h5A, 1};
    tbl[10] = '{1'b1, 1'b1, 13'h0020, 8'hC3, 1'b1, 2'd2, 8'h5A, 1};
    tbl[11] = '{1'b0, 1'b1, 13'h0020, 8'h00, 1'b0, 2'd0, 8'hC3, 1};

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 128; a++) mdl[b][a] = 8'h00;
    last_do = 8'hFF;
    cur_bank = 1'b0;

    reset = 1'b1; ce = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_di = '0;
    vbk_we = 1'b0; vbk_di = '0; lcd_on = 1'b0; lcd_mode = 2'd0; vid_rd = 1'b0; vid_addr = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_ack", cpu_ack, 1'b0);
    chk("rst_do", cpu_do, 8'hFF);
    chk("rst_vbk", vbk_do, 8'hFE);
    chk("rst_vid", vid_data, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      set_bank(tbl[i].bank);
      lcd_on = tbl[i].lon;
      lcd_mode = tbl[i].mode;
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].di, 0, tbl[i].exp_do, tbl[i].exp_lat, $sformatf("vec%0d", i));
    end
    lcd_on = 1'b0; lcd_mode = 2'd0;

    vid_rd = 1'b1; vid_addr = 13'h0010;
    step();
    vid_rd = 1'b0; vid_addr = 13'h0020;
    chk("vid_0010", vid_data, 16'h5AA5);
    step();
    chk("vid_hold", vid_data, 16'h5AA5);
    chk("vbk_bank1", vbk_do, 8'hFF);

    for (int b = 0; b < 2; b++) begin
      set_bank(b[0]);
      for (int a = 64; a < 128; a++)
        cpu_op(1'b1, 13'(a), 8'($urandom), 0, last_do, 1, "fill");
    end

    set_bank(1'b1);
    cpu_op(1'b0, 13'h0010, 8'h00, 3, 8'h5A, 4, "contend");

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vid_rd = 1'b1; vid_addr = 13'h0010;
    step();
    chk("bsw_wait_ack", cpu_ack, 1'b0);
    chk("bsw_vid", vid_data, 16'h5AA5);
    vbk_we = 1'b1; vbk_di = 8'h00;
    step();
    vbk_we = 1'b0; vid_rd = 1'b0;
    chk("bsw_wait2_ack", cpu_ack, 1'b0);
    chk("bsw_vbk", vbk_do, 8'hFE);
    step();
    cpu_req = 1'b0;
    chk("bsw_ack", cpu_ack, 1'b1);
    chk("bsw_do", cpu_do, 8'hA5);
    cur_bank = 1'b0; last_do = 8'hA5;
    step();
    chk("bsw_ackpulse", cpu_ack, 1'b0);

    set_bank(1'b1);
    lcd_on = 1'b1; lcd_mode = 2'd2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vid_rd = 1'b1; vid_addr = 13'h0040;
    step();
    chk("lkw_wait_ack", cpu_ack, 1'b0);
    chk("lkw_vid", vid_data, {mdl[1][64], mdl[0][64]});
    lcd_mode = 2'd3;
    step();
    chk("lkw_ack", cpu_ack, 1'b1);
    chk("lkw_do", cpu_do, 8'hFF);
    cpu_req = 1'b0; vid_rd = 1'b0; lcd_on = 1'b0; lcd_mode = 2'd0;
    last_do = 8'hFF;
    step();
    chk("lkw_ackpulse", cpu_ack, 1'b0);

    set_bank(1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    ce = 1'b0;
    step();
    chk("ce0_ack_a", cpu_ack, 1'b0);
    step();
    chk("ce0_ack_b", cpu_ack, 1'b0);
    ce = 1'b1;
    step();
    chk("ce1_ack", cpu_ack, 1'b1);
    chk("ce1_do", cpu_do, 8'hA5);
    ce = 1'b0; cpu_req = 1'b0;
    step();
    chk("ce0_ackfrozen", cpu_ack, 1'b1);
    ce = 1'b1;
    step();
    chk("ce_ackdrop", cpu_ack, 1'b0);
    chk("ce_dohold", cpu_do, 8'hA5);
    last_do = 8'hA5;

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 1) == 1) set_bank(1'($urandom_range(0, 1)));
      lcd_on = 1'($urandom_range(0, 1));
      lcd_mode = 2'($urandom_range(0, 3));
      we_r = 1'($urandom_range(0, 1));
      a_r = 7'($urandom_range(64, 127));
      d_r = 8'($urandom);
      lat_e = $urandom_range(0, 3);
      lk_r = lcd_on && (lcd_mode == 2'd3);
      if (we_r) e_r = last_do;
      else if (lk_r) e_r = 8'hFF;
      else e_r = mdl[cur_bank][a_r];
      cpu_op(we_r, {6'd0, a_r}, d_r, lat_e, e_r, lk_r ? 1 : lat_e + 1, "rnd");
    end
    lcd_on = 1'b0; lcd_mode = 2'd0;

    set_bank(1'b1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_di = 8'hEE;
    vid_rd = 1'b1; vid_addr = 13'h0040;
    step();
    chk("rmo_wait_ack", cpu_ack, 1'b0);
    reset = 1'b1;
    #2;
    chk("rmo_ack", cpu_ack, 1'b0);
    chk("rmo_do", cpu_do, 8'hFF);
    chk("rmo_vbk", vbk_do, 8'hFE);
    chk("rmo_vid", vid_data, 16'h0000);
    cpu_req = 1'b0; vid_rd = 1'b0;
    #1;
    reset = 1'b0;
    cur_bank = 1'b0; last_do = 8'hFF;
    step();
    chk("rmo_noack", cpu_ack, 1'b0);
    cpu_op(1'b0, 13'h0010, 8'h00, 0, 8'hA5, 1, "rmo_b0");
    set_bank(1'b1);
    cpu_op(1'b0, 13'h0010, 8'h00, 0, 8'h5A, 1, "rmo_b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
